// File: rtl/program_mem_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | program_mem_controller: round-robin arbiter of fetcher reads onto one    |
// | program-memory read channel, with valid/ready return path per fetcher.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module program_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
  output logic                                      mem_read_valid,
  output logic [ADDR_BITS-1:0]                      mem_read_address,
  input  logic                                      mem_read_ready,
  input  logic [DATA_BITS-1:0]                      mem_read_data
);

  localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [IDX_BITS-1:0] c_last_idx = IDX_BITS'(NUM_CONSUMERS - 1);
  localparam logic [IDX_BITS:0]   c_num      = (IDX_BITS + 1)'(NUM_CONSUMERS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    RELAY    = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDX_BITS-1:0] r_rr_ptr;
  logic [IDX_BITS-1:0] r_grant;
  logic [IDX_BITS-1:0] w_grant;
  logic [IDX_BITS-1:0] w_idx;
  logic [IDX_BITS:0]   w_sum;
  logic                w_any;

  // Scan requesters starting at the round-robin pointer, wrapping once.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDX_BITS + 1)'(k);
      if (w_sum >= c_num) begin
        w_sum = w_sum - c_num;
      end
      w_idx = w_sum[IDX_BITS-1:0];
      if (!w_any && consumer_read_valid[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state             <= IDLE;
      r_rr_ptr            <= '0;
      r_grant             <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
      mem_read_valid      <= 1'b0;
      mem_read_address    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant          <= w_grant;
            mem_read_valid   <= 1'b1;
            mem_read_address <= consumer_read_address[w_grant];
            r_state          <= WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          if (mem_read_ready) begin
            mem_read_valid               <= 1'b0;
            consumer_read_data[r_grant]  <= mem_read_data;
            consumer_read_ready[r_grant] <= 1'b1;
            r_state                      <= RELAY;
          end
        end
        RELAY: begin
          // Data is left in place after release; only ready is withdrawn.
          if (!consumer_read_valid[r_grant]) begin
            consumer_read_ready[r_grant] <= 1'b0;
            r_rr_ptr <= (r_grant == c_last_idx) ? '0 : r_grant + 1'b1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_mem_controller.sv
`default_nettype none
// Testbench for program_mem_controller: table-driven directed transactions,
// reset corner cases and randomized traffic against a transaction-level model.
module tb_program_mem_controller;

  logic             clk;
  logic             reset;
  logic [3:0]       consumer_read_valid;
  logic [3:0][7:0]  consumer_read_address;
  logic [3:0]       consumer_read_ready;
  logic [3:0][15:0] consumer_read_data;
  logic             mem_read_valid;
  logic [7:0]       mem_read_address;
  logic             mem_read_ready;
  logic [15:0]      mem_read_data;

  int checks = 0;
  int errors = 0;

  program_mem_controller #(
    .ADDR_BITS(8),
    .DATA_BITS(16),
    .NUM_CONSUMERS(4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .consumer_read_valid  (consumer_read_valid),
    .consumer_read_address(consumer_read_address),
    .consumer_read_ready  (consumer_read_ready),
    .consumer_read_data   (consumer_read_data),
    .mem_read_valid       (mem_read_valid),
    .mem_read_address     (mem_read_address),
    .mem_read_ready       (mem_read_ready),
    .mem_read_data        (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // At most one ready bit may ever be high.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ($countones(consumer_read_ready) > 1) begin
        errors++;
        $display("FAIL onehot_ready: got %b expected at most one bit", consumer_read_ready);
      end
    end
  end

  task automatic check_all_zero(input string nm);
    check({nm, "_ready"}, 64'(consumer_read_ready), 64'd0);
    check({nm, "_data"}, 64'(consumer_read_data), 64'd0);
    check({nm, "_mvalid"}, 64'(mem_read_valid), 64'd0);
    check({nm, "_maddr"}, 64'(mem_read_address), 64'd0);
  endtask

  // Serve one transaction expected to be granted to consumer g at address a.
  task automatic serve(input int g, input logic [7:0] a, input logic [15:0] d,
                       input int lat, input bit early, input bit rereq, input string nm);
    int n;
    logic [3:0][7:0] saved;
    n = 0;
    while (!mem_read_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_mem_valid_seen"}, 64'(mem_read_valid), 64'd1);
    if (!mem_read_valid) return;
    check({nm, "_mem_addr"}, 64'(mem_read_address), 64'(a));
    check({nm, "_ready_idle"}, 64'(consumer_read_ready), 64'd0);
    saved = consumer_read_address;
    consumer_read_address = {$urandom, $urandom};
    if (early) consumer_read_valid[g] = 1'b0;
    for (int i = 0; i < lat; i++) begin
      mem_read_data = 16'($urandom);
      @(negedge clk);
      check({nm, "_mem_hold_valid"}, 64'(mem_read_valid), 64'd1);
      check({nm, "_mem_hold_addr"}, 64'(mem_read_address), 64'(a));
    end
    mem_read_data  = d;
    mem_read_ready = 1'b1;
    @(negedge clk);
    mem_read_ready = 1'b0;
    mem_read_data  = 16'($urandom);
    check({nm, "_ready"}, 64'(consumer_read_ready), 64'(4'b0001 << g));
    check({nm, "_data"}, 64'(consumer_read_data[g]), 64'(d));
    check({nm, "_mem_valid_drop"}, 64'(mem_read_valid), 64'd0);
    consumer_read_address = saved;
    if (!early) begin
      @(negedge clk);
      check({nm, "_ready_hold"}, 64'(consumer_read_ready), 64'(4'b0001 << g));
      consumer_read_valid[g] = 1'b0;
    end
    @(negedge clk);
    check({nm, "_ready_release"}, 64'(consumer_read_ready), 64'd0);
    check({nm, "_data_kept"}, 64'(consumer_read_data[g]), 64'(d));
    if (rereq) consumer_read_valid[g] = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  set_req;
    bit          rereq;
    bit          early;
    int          grant;
    logic [15:0] data;
    int          lat;
  } vec_t;

  vec_t vecs[11];
  logic [3:0][7:0] c_addr;
  int model_rr;
  int g;

  initial begin
    c_addr = {8'h78, 8'h56, 8'h34, 8'h12};
    vecs[0]  = '{4'b0001, 1'b0, 1'b0, 0, 16'hBEEF, 3};
    vecs[1]  = '{4'b0100, 1'b0, 1'b0, 2, 16'h1111, 1};
    vecs[2]  = '{4'b1010, 1'b0, 1'b0, 3, 16'h3333, 2};
    vecs[3]  = '{4'b0000, 1'b0, 1'b0, 1, 16'h2222, 0};
    vecs[4]  = '{4'b0100, 1'b0, 1'b1, 2, 16'hE0E0, 2};
    vecs[5]  = '{4'b1000, 1'b0, 1'b0, 3, 16'h4444, 1};
    vecs[6]  = '{4'b1111, 1'b1, 1'b0, 0, 16'hA000, 1};
    vecs[7]  = '{4'b0000, 1'b1, 1'b0, 1, 16'hA001, 0};
    vecs[8]  = '{4'b0000, 1'b1, 1'b0, 2, 16'hA002, 2};
    vecs[9]  = '{4'b0000, 1'b1, 1'b0, 3, 16'hA003, 1};
    vecs[10] = '{4'b0000, 1'b0, 1'b0, 0, 16'hA004, 0};

    // Reset held low with random inputs.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      consumer_read_valid   = 4'($urandom);
      consumer_read_address = {$urandom, $urandom};
      mem_read_ready        = 1'($urandom);
      mem_read_data         = 16'($urandom);
      @(negedge clk);
      check_all_zero("reset_hold");
    end
    consumer_read_valid   = '0;
    consumer_read_address = c_addr;
    mem_read_ready        = 1'b0;
    mem_read_data         = '0;
    reset                 = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");

    // Directed transactions from the table.
    for (int v = 0; v < 11; v++) begin
      consumer_read_address = c_addr;
      consumer_read_valid   = consumer_read_valid | vecs[v].set_req;
      serve(vecs[v].grant, c_addr[vecs[v].grant], vecs[v].data, vecs[v].lat,
            vecs[v].early, vecs[v].rereq, $sformatf("vec%0d", v));
    end
    consumer_read_valid = '0;

    // Asynchronous reset while waiting for memory; a late response is ignored.
    consumer_read_valid[2] = 1'b1;
    for (int n = 0; n < 20 && !mem_read_valid; n++) @(negedge clk);
    check("abort_pre_mvalid", 64'(mem_read_valid), 64'd1);
    #2 reset = 1'b0;
    #1 check_all_zero("abort_async");
    @(negedge clk);
    consumer_read_valid = '0;
    reset = 1'b1;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_resp_ready", 64'(consumer_read_ready), 64'd0);
      check("late_resp_mvalid", 64'(mem_read_valid), 64'd0);
    end
    mem_read_ready = 1'b0;
    // Pointer was 1 before reset; after reset c0 must win over c3.
    consumer_read_valid = 4'b1001;
    serve(0, c_addr[0], 16'h0F0F, 1, 1'b0, 1'b0, "post_reset_rr");
    consumer_read_valid = '0;

    // Memory strobe while idle is ignored.
    mem_read_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_read_data = 16'($urandom);
      @(negedge clk);
      check("idle_mready_mvalid", 64'(mem_read_valid), 64'd0);
      check("idle_mready_ready", 64'(consumer_read_ready), 64'd0);
    end
    mem_read_ready = 1'b0;

    // Randomized traffic against a round-robin transaction model.
    model_rr = 1;
    for (int t = 0; t < 80; t++) begin
      consumer_read_valid = consumer_read_valid | 4'($urandom);
      if (consumer_read_valid == 4'b0) consumer_read_valid[$urandom_range(0, 3)] = 1'b1;
      consumer_read_address = {$urandom, $urandom};
      g = -1;
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && consumer_read_valid[(model_rr + k) % 4]) g = (model_rr + k) % 4;
      end
      serve(g, consumer_read_address[g], 16'($urandom), $urandom_range(0, 4),
            1'($urandom), 1'($urandom), $sformatf("rand%0d", t));
      model_rr = (g + 1) % 4;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
